// File: rtl/heartbeat_sseg_if.sv
`default_nettype none
// ============================================================================
// Module   : heartbeat_sseg_if
// Brief    : Display pin bundle for the heartbeat 7-segment driver.
//            an   - active-low one-hot digit enables (an[0] = rightmost)
//            sseg - active-low segments {dp,g,f,e,d,c,b,a}
// Revision : 1.0  initial release
// ============================================================================
interface heartbeat_sseg_if;
  logic [3:0] an;
  logic [7:0] sseg;

  // The driver owns the pins; the board or an observer only reads them.
  modport master (output an, output sseg);
  modport slave  (input  an, input  sseg);
endinterface
`default_nettype wire

// File: rtl/heartbeat_sseg.sv
`default_nettype none
// ============================================================================
// Module   : heartbeat_sseg
// Brief    : Four-digit common-anode 7-segment "heartbeat" animation.
//            A free-running refresh counter multiplexes the digits, and a
//            phase timer steps a three-phase pattern of vertical bars that
//            expand outward from the centre.
// Options  : define HEARTBEAT_DP_EN to light the digit-0 decimal point
//            while phase 0 is showing (one pulse dot per beat).
// Revision : 1.0  initial release
// ============================================================================
module heartbeat_sseg #(
  parameter int REFRESH_BITS = 18,
  parameter int PHASE_CYCLES = 27_777_778
) (
  input  wire                       clk,
  input  wire                       reset,
  heartbeat_sseg_if.master          disp_o
);

  localparam int TIMER_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PHASE_CYCLES - 1);

  // Segment codes, active-low {dp,g,f,e,d,c,b,a}.
  localparam logic [7:0] BLANK = 8'hFF;
  localparam logic [7:0] RBAR  = 8'b1111_1001;  // b,c lit
  localparam logic [7:0] LBAR  = 8'b1100_1111;  // e,f lit

  // Animation phases. Code 3 is never entered; it decodes like phase 0.
  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;

  logic [REFRESH_BITS-1:0] refresh_q;
  logic [TIMER_W-1:0]      timer_q;
  logic                    wrap;
  logic [1:0]              sel;
  logic [1:0]              phase_q, phase_d;
  logic [3:0]              an_d, an_q;
  logic [7:0]              sseg_d, sseg_q;

  assign sel  = refresh_q[REFRESH_BITS-1 -: 2];
  assign wrap = (timer_q == TIMER_LAST);

  // Free-running digit-multiplex counter and phase-length timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
      timer_q   <= '0;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      timer_q   <= wrap ? '0 : timer_q + 1'b1;
    end
  end

  // Phase state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase sequencing: advance only on the timer wrap; stray code 3 reloads 0.
  always_comb begin
    phase_d = phase_q;
    if (wrap) begin
      case (phase_q)
        PH0:     phase_d = PH1;
        PH1:     phase_d = PH2;
        default: phase_d = PH0;
      endcase
    end
  end

  // Digit enable and segment pattern for the current digit and phase.
  always_comb begin
    an_d   = 4'b1111;
    sseg_d = BLANK;
    case (sel)
      2'd0:    an_d = 4'b1110;
      2'd1:    an_d = 4'b1101;
      2'd2:    an_d = 4'b1011;
      default: an_d = 4'b0111;
    endcase
    case (phase_q)
      PH1: begin
        case (sel)
          2'd2:    sseg_d = LBAR;
          2'd1:    sseg_d = RBAR;
          default: sseg_d = BLANK;
        endcase
      end
      PH2: begin
        case (sel)
          2'd3:    sseg_d = LBAR;
          2'd0:    sseg_d = RBAR;
          default: sseg_d = BLANK;
        endcase
      end
      default: begin
        case (sel)
          2'd2:    sseg_d = RBAR;
          2'd1:    sseg_d = LBAR;
          default: sseg_d = BLANK;
        endcase
      end
    endcase
`ifdef HEARTBEAT_DP_EN
    if ((sel == 2'd0) && (phase_q != PH1) && (phase_q != PH2)) begin
      sseg_d[7] = 1'b0;
    end
`else
    sseg_d[7] = 1'b1;
`endif
  end

  // Pin registers: enable and segments switch on the same edge, dark in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= 4'b1111;
      sseg_q <= BLANK;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign disp_o.an   = an_q;
  assign disp_o.sseg = sseg_q;

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_sseg.sv
`default_nettype none
// ============================================================================
// Module   : tb_heartbeat_sseg
// Brief    : Scoreboard bench for heartbeat_sseg with a short refresh scan
//            (REFRESH_BITS=4) and short phases (PHASE_CYCLES=64).
// Revision : 1.0  initial release
// ============================================================================
module tb_heartbeat_sseg;

  localparam int RB = 4;
  localparam int PC = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  heartbeat_sseg_if u_if ();

  heartbeat_sseg #(
    .REFRESH_BITS (RB),
    .PHASE_CYCLES (PC)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .disp_o (u_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: value of each DUT counter before the next edge.
  int m_cnt   = 0;
  int m_timer = 0;
  int m_phase = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
  endtask

  function automatic logic [7:0] exp_seg(input int ph, input int dig);
    logic [7:0] s;
    s = 8'hFF;
    case (ph)
      0: if (dig == 2) s = 8'hF9; else if (dig == 1) s = 8'hCF;
      1: if (dig == 2) s = 8'hCF; else if (dig == 1) s = 8'hF9;
      2: if (dig == 3) s = 8'hCF; else if (dig == 0) s = 8'hF9;
      default: s = 8'hFF;
    endcase
`ifdef HEARTBEAT_DP_EN
    if (ph == 0 && dig == 0) s[7] = 1'b0;
`endif
    return s;
  endfunction

  // One clock: drive reset, predict the pins after the edge, then compare.
  task automatic step(input logic rst_v);
    exp_t e;
    exp_t got;
    int   dig;
    reset = rst_v;
    if (rst_v) begin
      e.an   = 4'b1111;
      e.sseg = 8'hFF;
      m_cnt = 0; m_timer = 0; m_phase = 0;
    end else begin
      dig    = (m_cnt >> (RB - 2)) & 3;
      e.an   = ~(4'b0001 << dig);
      e.sseg = exp_seg(m_phase, dig);
      m_cnt  = (m_cnt + 1) % (1 << RB);
      if (m_timer == PC - 1) begin
        m_timer = 0;
        m_phase = (m_phase + 1) % 3;
      end else begin
        m_timer++;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      got.an   = u_if.an;
      got.sseg = u_if.sseg;
      check_eq(rst_v ? "reset_an" : "an", 32'(got.an), 32'(e.an));
      check_eq(rst_v ? "reset_sseg" : "sseg", 32'(got.sseg), 32'(e.sseg));
    end
  endtask

  initial begin
    // Power-up reset, 5 cycles.
    for (int i = 0; i < 5; i++) step(1'b1);
    // Phases 0,1,2 and the return to phase 0.
    for (int i = 0; i < 3 * PC + 20; i++) step(1'b0);
    // Move into the middle of phase 2.
    for (int i = 0; i < 2 * PC + 10; i++) step(1'b0);
    check_eq("model_in_phase2", 32'(m_phase), 32'd2);
    // Single-cycle reset mid-animation, then a full phase 0 and beyond.
    step(1'b1);
    for (int i = 0; i < PC + 8; i++) step(1'b0);
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
